// File: rtl/signal_conflict_monitor_pkg.sv
// Shared lamp-bus definitions: colour encodings, fault codes,
// lamp indices, group membership and a lowest-index helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10,
        BAD    = 2'b11
    } lamp_t;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_CONFLICT = 3'd1,
        FLT_INVALID  = 3'd2,
        FLT_TRANS    = 3'd3,
        FLT_SHORT_G  = 3'd4,
        FLT_SHORT_Y  = 3'd5,
        FLT_STUCK    = 3'd6
    } fault_t;

    localparam int N_LAMPS = 8;

    localparam int LAMP_N_FWD  = 0;
    localparam int LAMP_N_LEFT = 1;
    localparam int LAMP_S_FWD  = 2;
    localparam int LAMP_S_LEFT = 3;
    localparam int LAMP_E_FWD  = 4;
    localparam int LAMP_E_LEFT = 5;
    localparam int LAMP_W_FWD  = 6;
    localparam int LAMP_W_LEFT = 7;

    // Compatible group of each lamp, lamp 0 in the low bits.
    localparam logic [N_LAMPS-1:0][1:0] LAMP_GROUP = {
        2'd3, 2'd1, 2'd3, 2'd1,
        2'd2, 2'd0, 2'd2, 2'd0
    };

    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Intersection lamp bus: eight 2-bit lamps.
// master = traffic controller (drives), slave = monitor (observes).
interface signal_conflict_monitor_if;

    logic [1:0] N_forward;
    logic [1:0] N_left;
    logic [1:0] S_forward;
    logic [1:0] S_left;
    logic [1:0] E_forward;
    logic [1:0] E_left;
    logic [1:0] W_forward;
    logic [1:0] W_left;

    modport master (
        output N_forward, N_left, S_forward, S_left,
        output E_forward, E_left, W_forward, W_left
    );

    modport slave (
        input N_forward, N_left, S_forward, S_left,
        input E_forward, E_left, W_forward, W_left
    );

endinterface

// File: rtl/signal_conflict_monitor_tracker.sv
// Per-lamp tracker: previous colour and dwell counter.
// Ports: clk, reset, prev_valid, lamp in; illegal_trans, short_green,
// short_yellow, changed out (all combinational on current sample).
module lamp_tracker
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN           = 3,
    parameter int MIN_YELLOW          = 3,
    parameter int REQUIRE_LEFT_YELLOW = 0,
    parameter int is_left             = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prev_valid,
    input  logic [1:0] lamp,
    output logic       illegal_trans,
    output logic       short_green,
    output logic       short_yellow,
    output logic       changed
);

    localparam int DMAX = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
    localparam int DW   = $clog2(DMAX + 1);

    localparam logic [DW-1:0] D_SAT = DW'(DMAX);
    localparam logic [DW-1:0] G_MIN = DW'(MIN_GREEN);
    localparam logic [DW-1:0] Y_MIN = DW'(MIN_YELLOW);

    localparam bit LEFT_G2R = (is_left != 0) && (REQUIRE_LEFT_YELLOW == 0);

    logic [1:0]    prev;
    logic [DW-1:0] dwell;
    logic          step;

    // Anything touching the 11 encoding is reported as invalid only.
    assign step = prev_valid && (lamp != prev) &&
                  (lamp != BAD) && (prev != BAD);

    assign changed = prev_valid && (lamp != prev);

    always_comb begin
        illegal_trans = 1'b0;
        short_green   = 1'b0;
        short_yellow  = 1'b0;
        if (step) begin
            unique case (prev)
                GREEN: begin
                    illegal_trans = (lamp == RED) && !LEFT_G2R;
                    short_green   = dwell < G_MIN;
                end
                YELLOW: begin
                    illegal_trans = (lamp != RED);
                    short_yellow  = dwell < Y_MIN;
                end
                RED: begin
                    illegal_trans = (lamp != GREEN);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev  <= RED;
            dwell <= '0;
        end else begin
            prev <= lamp;
            if (!prev_valid || (lamp != prev)) begin
                dwell <= DW'(1);
            end else if (dwell != D_SAT) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Lamp-bus safety monitor: conflict, encoding, sequence, dwell, stuck.
// Ports: clk, reset, bus (slave), fault_clr in; fault, fault_code,
// fault_lamp, flash_req out (registered, first fault latched).
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN           = 3,
    parameter int MIN_YELLOW          = 3,
    parameter int MAX_STUCK           = 15,
    parameter int REQUIRE_LEFT_YELLOW = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    signal_conflict_monitor_if.slave       bus,
    input  logic                           fault_clr,
    output logic                           fault,
    output logic [2:0]                     fault_code,
    output logic [2:0]                     fault_lamp,
    output logic                           flash_req
);

    localparam int SW = $clog2(MAX_STUCK + 1);

    localparam logic [SW-1:0] S_SAT = SW'(MAX_STUCK);
    localparam logic [SW-1:0] S_HIT = SW'(MAX_STUCK - 1);

    logic [N_LAMPS-1:0][1:0] lamps;
    logic [N_LAMPS-1:0]      illegal;
    logic [N_LAMPS-1:0]      short_g;
    logic [N_LAMPS-1:0]      short_y;
    logic [N_LAMPS-1:0]      changed;
    logic [N_LAMPS-1:0]      nonred;
    logic [N_LAMPS-1:0]      invalid;
    logic [3:0]              grp_act;
    logic                    conflict;
    logic                    unchanged;
    logic                    stuck_viol;
    logic                    viol;
    fault_t                  nxt_code;
    logic [2:0]              nxt_lamp;
    logic                    prev_valid;
    logic [SW-1:0]           stuck_cnt;

    assign lamps = {
        bus.W_left, bus.W_forward, bus.E_left, bus.E_forward,
        bus.S_left, bus.S_forward, bus.N_left, bus.N_forward
    };

    for (genvar i = 0; i < N_LAMPS; i++) begin : g_trk
        lamp_tracker #(
            .MIN_GREEN           (MIN_GREEN),
            .MIN_YELLOW          (MIN_YELLOW),
            .REQUIRE_LEFT_YELLOW (REQUIRE_LEFT_YELLOW),
            .is_left             (i % 2)
        ) u_trk (
            .clk           (clk),
            .reset         (reset),
            .prev_valid    (prev_valid),
            .lamp          (lamps[i]),
            .illegal_trans (illegal[i]),
            .short_green   (short_g[i]),
            .short_yellow  (short_y[i]),
            .changed       (changed[i])
        );
        assign nonred[i]  = (lamps[i] != RED);
        assign invalid[i] = (lamps[i] == BAD);
    end

    always_comb begin
        grp_act = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            if (nonred[i]) grp_act[LAMP_GROUP[i]] = 1'b1;
        end
    end

    // Two or more groups showing anything but RED.
    assign conflict = (grp_act & (grp_act - 4'd1)) != 4'd0;

    assign unchanged  = prev_valid && !(|changed);
    assign stuck_viol = unchanged && (stuck_cnt == S_HIT);

    always_comb begin
        viol     = 1'b1;
        nxt_code = FLT_NONE;
        nxt_lamp = '0;
        if (conflict) begin
            nxt_code = FLT_CONFLICT;
            nxt_lamp = first_set(nonred);
        end else if (|invalid) begin
            nxt_code = FLT_INVALID;
            nxt_lamp = first_set(invalid);
        end else if (|illegal) begin
            nxt_code = FLT_TRANS;
            nxt_lamp = first_set(illegal);
        end else if (|short_g) begin
            nxt_code = FLT_SHORT_G;
            nxt_lamp = first_set(short_g);
        end else if (|short_y) begin
            nxt_code = FLT_SHORT_Y;
            nxt_lamp = first_set(short_y);
        end else if (stuck_viol) begin
            nxt_code = FLT_STUCK;
        end else begin
            viol = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            stuck_cnt  <= '0;
            fault      <= 1'b0;
            fault_code <= '0;
            fault_lamp <= '0;
        end else begin
            prev_valid <= 1'b1;

            if (fault_clr && !viol) begin
                stuck_cnt <= '0;
            end else if (unchanged) begin
                if (stuck_cnt != S_SAT) stuck_cnt <= stuck_cnt + 1'b1;
            end else begin
                stuck_cnt <= '0;
            end

            // A clear request never hides a violation seen the same cycle.
            if (viol && (!fault || fault_clr)) begin
                fault      <= 1'b1;
                fault_code <= nxt_code;
                fault_lamp <= nxt_lamp;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= '0;
                fault_lamp <= '0;
            end
        end
    end

    assign flash_req = fault;

endmodule

// File: doc/signal_conflict_monitor.md
# signal_conflict_monitor

Safety monitor on the consuming end of the intersection lamp bus. It samples the eight 2-bit lamp outputs driven by the traffic controller every cycle and checks four things: conflicting movements, illegal encodings and colour sequences, minimum green/yellow dwell, and a stuck controller. The first violation is latched as a fault with a code and lamp index, and `flash_req` is raised for the lamp driver. The block sits between the controller and the lamp drivers and is purely observational; it never alters the lamp bus.

## Interface
- `MIN_GREEN`, 3: minimum cycles a lamp must stay GREEN before leaving GREEN.
- `MIN_YELLOW`, 3: minimum cycles a lamp must stay YELLOW before leaving YELLOW.
- `MAX_STUCK`, 15: consecutive cycles with no lamp change that raise a stuck fault.
- `REQUIRE_LEFT_YELLOW`, 0: when 1, left lamps must also pass through YELLOW (GREEN->RED becomes illegal).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `N_forward`, `N_left`, `S_forward`, `S_left`, `E_forward`, `E_left`, `W_forward`, `W_left` in 2 each: lamp bus. RED=00, YELLOW=01, GREEN=10, 11 is invalid.
- `fault_clr` in 1: single-cycle request to clear a latched fault.
- `fault` out 1: a fault is latched.
- `fault_code` out 3: 0 none, 1 conflict, 2 invalid encoding, 3 illegal transition, 4 short green, 5 short yellow, 6 stuck.
- `fault_lamp` out 3: lamp index of the latched fault.
- `flash_req` out 1: equals `fault`.

## Operation
- **Lamp index:** 0 N_forward, 1 N_left, 2 S_forward, 3 S_left, 4 E_forward, 5 E_left, 6 W_forward, 7 W_left.
- **Compatible groups:** G0={N_f,S_f}, G1={E_f,W_f}, G2={N_l,S_l}, G3={E_l,W_l}.
  - **Conflict:** non-RED lamps present in two or more groups in the same cycle.
  - `fault_lamp` for a conflict is the lowest-index non-RED lamp.
- **Invalid encoding:** any lamp == 11.
- **Legal transitions:** hold, R->G, G->Y, Y->R.
  - G->R is legal only for left lamps, and only when REQUIRE_LEFT_YELLOW=0.
  - R->Y and Y->G are always illegal.
  - Transitions into or out of 11 are covered by code 2 only.
- **Dwell counting:**
  - Each lamp has a dwell counter set to 1 on the first cycle of a new colour.
  - It increments while the colour holds and saturates at max(MIN_GREEN, MIN_YELLOW).
  - Leaving GREEN with dwell < MIN_GREEN is a short-green fault.
  - Leaving YELLOW with dwell < MIN_YELLOW is a short-yellow fault.
- **Stuck detection:**
  - The stuck counter increments each cycle in which all eight lamps equal their previous sample, and resets to 0 on any change.
  - The fault fires when the counter reaches MAX_STUCK.
  - `fault_lamp`=0 for a stuck fault.
- **First cycle after reset:** `prev_valid`=0. Transition, dwell and stuck checks are suppressed; conflict and encoding checks are active.
- **Simultaneous violations:** the lowest code wins. Within one code, the lowest lamp index wins.
- **Latching:**
  - While `fault`=1, `fault_code` and `fault_lamp` are frozen.
  - Lamp tracking (previous colour, dwell, stuck counter) continues regardless.
- **Clearing:**
  - `fault_clr`=1 with no violation that cycle clears `fault`, `fault_code` and `fault_lamp` to 0 and zeroes the stuck counter.
  - `fault_clr`=1 with a violation that cycle latches the new fault instead.
- **Reset:** overrides everything.

## Timing
- Inputs are sampled at each rising edge. A violation present on the bus in cycle n gives `fault`=1 with code and lamp in cycle n+1 (1-cycle latency, registered outputs).
- **Reset values:** `fault`=0, `fault_code`=0, `fault_lamp`=0, `flash_req`=0, `prev_valid`=0, all dwell counters 0, stuck counter 0.
- **Reset mid-fault:** the fault clears on the edge where `reset` is sampled high. Monitoring restarts as from power-up.
- **Stuck timing:** with the bus frozen from cycle k, the stuck counter hits MAX_STUCK at edge k+MAX_STUCK and `fault` is seen the following cycle.
- **Counter widths:**
  - Dwell: $clog2(max(MIN_GREEN, MIN_YELLOW)+1).
  - Stuck: $clog2(MAX_STUCK+1).
  - Both are unsigned and saturating, never wrap.

## Structure
- **Shared package `traffic_pkg`:**
  - Lamp encodings RED/YELLOW/GREEN.
  - Fault code constants FLT_NONE..FLT_STUCK.
  - Lamp index constants.
  - Group membership constant (8x2-bit group id).
- **Sub-module `lamp_tracker`**, instantiated 8×:
  - Holds previous colour and dwell counter.
  - Outputs per-lamp `illegal_trans`, `short_green`, `short_yellow` and `changed`.
  - Takes an `is_left` parameter.
- **Top level:** group conflict reduction, priority encoder, stuck counter, fault latch.

## Test plan
- **Clean run:** connect to the traffic controller, reset, run 200 cycles -> `fault`=0 throughout, including around the all-red state.
- **Conflict:** from all RED, drive N_forward=GREEN and E_forward=GREEN in cycle 5 -> cycle 6 `fault`=1, `fault_code`=1, `fault_lamp`=0, `flash_req`=1. Values stay frozen while the bus changes.
- **Priority:** same cycle S_left=11 and N_forward+E_left GREEN -> `fault_code`=1, `fault_lamp`=0. After `fault_clr` with a clean bus, the next cycle shows `fault`=0.
- **Illegal and short dwell:**
  - N_forward R->G, 3 cycles G, then directly R -> code 3, lamp 0.
  - Repeat with REQUIRE_LEFT_YELLOW=0 on N_left -> no fault.
  - E_forward G 3 cycles, Y 2 cycles, R -> code 5, lamp 4.
  - G for 2 cycles then Y -> code 4.
- **Stuck:** hold the bus all RED from cycle 10 -> `fault`=1, code 6 in cycle 26 (MAX_STUCK=15). With a lamp toggle at cycle 20 -> no fault until cycle 36.
- **Reset mid-fault:** latch code 1, assert `reset` for 1 cycle -> all outputs 0 the next cycle. An immediate G->R on the first post-reset cycle is not flagged (`prev_valid`=0).
